seq_code_matcher: RTL and testbench

- Parametrised successor to the 4-digit cypher datapath. Integrates datapath and FSM into one block.
- Accepts code digits over a valid/ready handshake and compares each digit in order against a CODE_LEN-digit cypher.
- Accumulates a digit sum, reports success or failure, and enforces a timed lockout after MAX_FAIL failed attempts.
- Sits between the keypad input stage and the top-level lock controller.

---
 rtl/seq_code_matcher.sv | 134 +++++++++++++
 tb/tb_seq_code_matcher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_code_matcher.sv
// Sequential code matcher: checks handshaked digits in order against a cypher,
// accumulates a digit sum, and applies a timed lockout after repeated failures.
module seq_code_matcher #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned SUM_W          = 8,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    localparam int unsigned IDX_W         = $clog2(CODE_LEN + 1),
    localparam int unsigned FC_W          = $clog2(MAX_FAIL + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CODE_LEN*DIGIT_W-1:0]  cypher,
    input  logic                         in_valid,
    input  logic [DIGIT_W-1:0]           in_digit,
    input  logic                         clear,
    output logic                         in_ready,
    output logic [IDX_W-1:0]             index,
    output logic [SUM_W-1:0]             sum,
    output logic                         success,
    output logic                         fail,
    output logic                         locked_out,
    output logic [FC_W-1:0]              fail_count
);

    localparam int unsigned CNT_W = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ENTRY   = 2'b00,
        SUCCESS = 2'b01,
        LOCKOUT = 2'b10
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   index_next;
    logic [SUM_W-1:0]   sum_next;
    logic [FC_W-1:0]    fc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               fail_next;
    logic [DIGIT_W-1:0] expected;
    logic               accept;

    assign in_ready = (state == ENTRY) && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        expected = '0;
        for (int unsigned k = 0; k < CODE_LEN; k++) begin
            if (index == IDX_W'(k)) expected = cypher[k*DIGIT_W +: DIGIT_W];
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        sum_next   = sum;
        fc_next    = fail_count;
        cnt_next   = cnt;
        fail_next  = 1'b0;
        case (state)
            ENTRY: begin
                if (clear) begin
                    index_next = '0;
                    sum_next   = '0;
                end else if (accept) begin
                    if (in_digit == expected) begin
                        index_next = index + IDX_W'(1);
                        sum_next   = sum + SUM_W'(in_digit);
                        if (index_next == IDX_W'(CODE_LEN)) state_next = SUCCESS;
                    end else begin
                        index_next = '0;
                        sum_next   = '0;
                        fail_next  = 1'b1;
                        if (fail_count == FC_W'(MAX_FAIL - 1)) begin
                            fc_next    = FC_W'(MAX_FAIL);
                            cnt_next   = CNT_W'(LOCKOUT_CYCLES);
                            state_next = LOCKOUT;
                        end else begin
                            fc_next = fail_count + FC_W'(1);
                        end
                    end
                end
            end
            SUCCESS: begin
                if (clear) begin
                    state_next = ENTRY;
                    index_next = '0;
                    sum_next   = '0;
                    fc_next    = '0;
                end
            end
            LOCKOUT: begin
                cnt_next = cnt - CNT_W'(1);
                // A zero count can only come from corruption; treat it as expiry.
                if (cnt <= CNT_W'(1)) begin
                    state_next = ENTRY;
                    fc_next    = '0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ENTRY;
                index_next = '0;
                sum_next   = '0;
                fc_next    = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ENTRY;
            index      <= '0;
            sum        <= '0;
            fail_count <= '0;
            cnt        <= '0;
            success    <= 1'b0;
            fail       <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_next;
            index      <= index_next;
            sum        <= sum_next;
            fail_count <= fc_next;
            cnt        <= cnt_next;
            success    <= (state_next == SUCCESS);
            fail       <= fail_next;
            locked_out <= (state_next == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_seq_code_matcher.sv
// Self-checking bench for seq_code_matcher: directed table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_seq_code_matcher;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // default-parameter instance
    logic [15:0] cyp0;
    logic        v0, c0, rdy0, succ0, fail0, lock0;
    logic [3:0]  d0;
    logic [2:0]  idx0;
    logic [7:0]  sum0;
    logic [1:0]  fc0;

    // narrow accumulator instance
    logic [15:0] cyp1;
    logic        v1, c1, rdy1, succ1, fail1, lock1;
    logic [3:0]  d1;
    logic [2:0]  idx1;
    logic [4:0]  sum1;
    logic [1:0]  fc1;

    // six-digit, 3-bit-digit instance
    logic [17:0] cyp2;
    logic        v2, c2, rdy2, succ2, fail2, lock2;
    logic [2:0]  d2;
    logic [2:0]  idx2;
    logic [7:0]  sum2;
    logic [1:0]  fc2;

    seq_code_matcher u0 (
        .clock(clock), .reset(reset), .cypher(cyp0), .in_valid(v0), .in_digit(d0),
        .clear(c0), .in_ready(rdy0), .index(idx0), .sum(sum0), .success(succ0),
        .fail(fail0), .locked_out(lock0), .fail_count(fc0)
    );

    seq_code_matcher #(.SUM_W(5)) u1 (
        .clock(clock), .reset(reset), .cypher(cyp1), .in_valid(v1), .in_digit(d1),
        .clear(c1), .in_ready(rdy1), .index(idx1), .sum(sum1), .success(succ1),
        .fail(fail1), .locked_out(lock1), .fail_count(fc1)
    );

    seq_code_matcher #(.CODE_LEN(6), .DIGIT_W(3)) u2 (
        .clock(clock), .reset(reset), .cypher(cyp2), .in_valid(v2), .in_digit(d2),
        .clear(c2), .in_ready(rdy2), .index(idx2), .sum(sum2), .success(succ2),
        .fail(fail2), .locked_out(lock2), .fail_count(fc2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an attempt is a count of matched digits; success is a
    // full count, lockout is a remaining-cycles budget.
    int m_idx, m_sum, m_fails, m_lock, m_fail;

    task automatic m_reset();
        m_idx = 0; m_sum = 0; m_fails = 0; m_lock = 0; m_fail = 0;
    endtask

    function automatic int m_ready(input logic c);
        return (m_lock == 0 && m_idx != 4 && !c) ? 1 : 0;
    endfunction

    task automatic m_edge(input logic v, input logic [3:0] d, input logic c);
        int want;
        m_fail = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_idx == 4) begin
            if (c) begin m_idx = 0; m_sum = 0; m_fails = 0; end
        end else if (c) begin
            m_idx = 0; m_sum = 0;
        end else if (v) begin
            want = (int'(cyp0) >> (4 * m_idx)) & 15;
            if (int'(d) == want) begin
                m_idx++;
                m_sum = (m_sum + int'(d)) % 256;
            end else begin
                m_idx = 0; m_sum = 0; m_fail = 1; m_fails++;
                if (m_fails == 3) m_lock = 16;
            end
        end
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        v0 = v; d0 = d; c0 = c;
        #1;
        chk("in_ready", rdy0, m_ready(c));
        @(posedge clock);
        m_edge(v, d, c);
        #1;
        chk("index", idx0, m_idx);
        chk("sum", sum0, m_sum);
        chk("success", succ0, (m_idx == 4) ? 1 : 0);
        chk("fail", fail0, m_fail);
        chk("locked_out", lock0, (m_lock > 0) ? 1 : 0);
        chk("fail_count", fc0, m_fails);
    endtask

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       c;
        logic       rdy;
        int         idx;
        int         sm;
        logic       sc;
        logic       fl;
        int         fc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        logic v;
        logic c;
        logic [3:0] dg;

        tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1,  1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'd2, 1'b0, 1'b1, 2,  3, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 4'd3, 1'b0, 1'b1, 3,  6, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 4'd4, 1'b0, 1'b1, 4, 10, 1'b1, 1'b0, 0};
        tbl[4]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4, 10, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1,  1, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1, 4'd2, 1'b0, 1'b1, 2,  3, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1, 4'd9, 1'b0, 1'b1, 0,  0, 1'b0, 1'b1, 1};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 0,  0, 1'b0, 1'b0, 1};
        tbl[10] = '{1'b1, 4'd1, 1'b0, 1'b1, 1,  1, 1'b0, 1'b0, 1};
        tbl[11] = '{1'b1, 4'd2, 1'b0, 1'b1, 2,  3, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b1, 4'd3, 1'b0, 1'b1, 3,  6, 1'b0, 1'b0, 1};
        tbl[13] = '{1'b1, 4'd4, 1'b0, 1'b1, 4, 10, 1'b1, 1'b0, 1};
        tbl[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 0};

        cyp0 = 16'h4321; v0 = 1'b0; d0 = '0; c0 = 1'b0;
        cyp1 = 16'hFFFF; v1 = 1'b0; d1 = '0; c1 = 1'b0;
        cyp2 = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        v2 = 1'b0; d2 = '0; c2 = 1'b0;
        m_reset();

        #12;
        chk("rst_index", idx0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_success", succ0, 0);
        chk("rst_fail", fail0, 0);
        chk("rst_locked", lock0, 0);
        chk("rst_fail_count", fc0, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // directed table: full match, ignored digits in SUCCESS, mismatch, retry
        for (int i = 0; i < 15; i++) begin
            v0 = tbl[i].v; d0 = tbl[i].d; c0 = tbl[i].c;
            #1;
            chk("tbl_ready", rdy0, tbl[i].rdy);
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk("tbl_index", idx0, tbl[i].idx);
            chk("tbl_sum", sum0, tbl[i].sm);
            chk("tbl_success", succ0, tbl[i].sc);
            chk("tbl_fail", fail0, tbl[i].fl);
            chk("tbl_fail_count", fc0, tbl[i].fc);
        end

        // three wrong digits -> lockout of exactly 16 cycles, inputs ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd7, 1'b0);
            chk("lock_fail_pulse", fail0, 1);
        end
        chk("lock_enter", lock0, 1);
        n = 0;
        while (lock0 === 1'b1 && n < 40) begin
            n++;
            step(1'b1, 4'd1, n[0]);
            if (lock0 === 1'b1) chk("lock_ready", rdy0, 0);
        end
        chk("lock_len", n, 16);
        chk("lock_exit_fc", fc0, 0);
        chk("lock_exit_index", idx0, 0);
        v0 = 1'b0; c0 = 1'b0;
        #1;
        chk("lock_exit_ready", rdy0, 1);
        @(posedge clock);
        #1;

        // clear beats in_valid mid-attempt; fail_count preserved
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b1);
        chk("clr_index", idx0, 0);
        chk("clr_sum", sum0, 0);
        chk("clr_fail_count", fc0, 1);

        // asynchronous reset between edges mid-attempt
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        v0 = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_index", idx0, 0);
        chk("arst_sum", sum0, 0);
        chk("arst_success", succ0, 0);
        chk("arst_fail", fail0, 0);
        chk("arst_locked", lock0, 0);
        chk("arst_fail_count", fc0, 0);
        m_reset();
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // randomized traffic, including occasional cypher changes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) cyp0 = 16'($urandom);
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 29) == 0);
            if (m_idx < 4 && $urandom_range(0, 3) != 0)
                dg = 4'((int'(cyp0) >> (4 * m_idx)) & 15);
            else
                dg = 4'($urandom);
            step(v, dg, c);
        end
        v0 = 1'b0; c0 = 1'b0;

        // SUM_W=5: F,F,F,F wraps to 28
        v1 = 1'b1; d1 = 4'hF;
        repeat (4) @(posedge clock);
        #1;
        v1 = 1'b0;
        chk("w5_success", succ1, 1);
        chk("w5_sum", sum1, 28);
        chk("w5_index", idx1, 4);
        chk("w5_fail", fail1, 0);

        // CODE_LEN=6, DIGIT_W=3 with random gaps between digits
        for (int k = 0; k < 6; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            v2 = 1'b1; d2 = 3'(k + 1);
            @(posedge clock);
            #1;
            v2 = 1'b0;
            chk("cl6_index", idx2, k + 1);
        end
        chk("cl6_success", succ2, 1);
        chk("cl6_sum", sum2, 21);
        chk("cl6_ready", rdy2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
